lt24_pixel_writer: RTL

Pixel-interface responder for the LT24 (ILI9341) panel: accepts `xAddr`/`yAddr`/`pixelData` writes from a pattern or image generator via a `pixelWrite`/`pixelReady` handshake. Each write becomes an 8080-style bus sequence (column set, page set, memory write, pixel word) on the LT24 parallel bus. It sits between the application pixel generator and the LT24 pins, replacing the pixel path of the display core. Panel power-up initialisation is out of scope and handled by a separate block.

---
 rtl/lt24_pixel_writer_if.sv | 24 ++
 rtl/lt24_pixel_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lt24_pixel_writer_if.sv
// Pixel request handshake plus LT24 8080 parallel bus pins for lt24_pixel_writer.
// master = pixel generator / bench side, slave = the writer itself.
interface lt24_pixel_writer_if;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic        LT24Wr_n;
  logic        LT24Rd_n;
  logic        LT24CS_n;
  logic        LT24RS;
  logic [15:0] LT24Data;

  modport master (
    output xAddr, yAddr, pixelData, pixelWrite,
    input  pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data
  );

  modport slave (
    input  xAddr, yAddr, pixelData, pixelWrite,
    output pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data
  );
endinterface

// File: rtl/lt24_pixel_writer.sv
// Turns single pixel writes into ILI9341 column/page/memory-write bus sequences.
// Define LT24_STREAM_EN to send only the pixel word for consecutive pixels.
//
// state    | meaning
// IDLE     | ready for a request; bus released
// CMD_COL  | column address set command 0x2A
// DAT_COL  | four column bytes: start hi/lo, end hi/lo
// CMD_PAGE | page address set command 0x2B
// DAT_PAGE | four page bytes: start hi/lo, end hi/lo
// CMD_MEM  | memory write command 0x2C
// PIXEL    | RGB565 pixel word (RS=1)
module lt24_pixel_writer #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input logic                clock,
  input logic                globalReset,
  lt24_pixel_writer_if.slave bus
);
  localparam int CNT_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [15:0]   X_END     = 16'(WIDTH - 1);
  localparam logic [15:0]   Y_END     = 16'(HEIGHT - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(WR_HIGH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_COL, DAT_COL, CMD_PAGE, DAT_PAGE, CMD_MEM, PIXEL
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic          hi, hi_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    x_q, x_nx;
  logic [8:0]    y_q, y_nx;
  logic [15:0]   pix_q, pix_nx;
  logic          wr_n_q, cs_n_q, rs_q, ready_q;
  logic          wr_n_nx, cs_n_nx, rs_nx, ready_nx;
  logic [15:0]   data_q, data_nx;
  logic          in_range;
  logic          hit;

  assign in_range = (32'(bus.xAddr) < 32'(WIDTH)) && (32'(bus.yAddr) < 32'(HEIGHT));

`ifdef LT24_STREAM_EN
  logic [7:0] prev_x, prev_x_nx;
  logic [7:0] win_x0, win_x0_nx;
  logic [8:0] prev_y, prev_y_nx;
  logic       stream_valid, stream_valid_nx;

  // Second term follows the panel's own wrap from the window end back to win_x0.
  assign hit = stream_valid &&
               (((bus.yAddr == prev_y) && ({1'b0, bus.xAddr} == {1'b0, prev_x} + 9'd1)) ||
                ((prev_x == X_END[7:0]) && (bus.xAddr == win_x0) &&
                 ({1'b0, bus.yAddr} == {1'b0, prev_y} + 10'd1)));
`else
  assign hit = 1'b0;
`endif

  function automatic logic [15:0] addr_byte(logic [1:0] i, logic [15:0] start, logic [15:0] stop);
    case (i)
      2'd0:    addr_byte = {8'h00, start[15:8]};
      2'd1:    addr_byte = {8'h00, start[7:0]};
      2'd2:    addr_byte = {8'h00, stop[15:8]};
      default: addr_byte = {8'h00, stop[7:0]};
    endcase
  endfunction

  // Returns {RS, data} for the bus word belonging to a state/index.
  function automatic logic [16:0] word_of(state_t s, logic [1:0] i, logic [7:0] x,
                                          logic [8:0] y, logic [15:0] p);
    word_of = {1'b1, 16'h0000};
    case (s)
      CMD_COL:  word_of = {1'b0, 16'h002A};
      DAT_COL:  word_of = {1'b1, addr_byte(i, {8'h00, x}, X_END)};
      CMD_PAGE: word_of = {1'b0, 16'h002B};
      DAT_PAGE: word_of = {1'b1, addr_byte(i, {7'h00, y}, Y_END)};
      CMD_MEM:  word_of = {1'b0, 16'h002C};
      PIXEL:    word_of = {1'b1, p};
      default:  word_of = {1'b1, 16'h0000};
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    hi_nx    = hi;
    cnt_nx   = cnt;
    x_nx     = x_q;
    y_nx     = y_q;
    pix_nx   = pix_q;
`ifdef LT24_STREAM_EN
    prev_x_nx       = prev_x;
    prev_y_nx       = prev_y;
    win_x0_nx       = win_x0;
    stream_valid_nx = stream_valid;
    if (state == IDLE && bus.pixelWrite && !in_range) stream_valid_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.pixelWrite && in_range) begin
          x_nx     = bus.xAddr;
          y_nx     = bus.yAddr;
          pix_nx   = bus.pixelData;
          idx_nx   = 2'd0;
          hi_nx    = 1'b0;
          cnt_nx   = LOW_LOAD;
          state_nx = hit ? PIXEL : CMD_COL;
`ifdef LT24_STREAM_EN
          prev_x_nx = bus.xAddr;
          prev_y_nx = bus.yAddr;
          if (!hit) win_x0_nx = bus.xAddr;
`endif
        end
      end
      default: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (!hi) begin
          hi_nx  = 1'b1;
          cnt_nx = HIGH_LOAD;
        end else begin
          hi_nx  = 1'b0;
          cnt_nx = LOW_LOAD;
          case (state)
            CMD_COL: begin
              state_nx = DAT_COL;
              idx_nx   = 2'd0;
            end
            DAT_COL: begin
              idx_nx = idx + 2'd1;
              if (idx == 2'd3) state_nx = CMD_PAGE;
            end
            CMD_PAGE: begin
              state_nx = DAT_PAGE;
              idx_nx   = 2'd0;
            end
            DAT_PAGE: begin
              idx_nx = idx + 2'd1;
              if (idx == 2'd3) state_nx = CMD_MEM;
            end
            CMD_MEM: state_nx = PIXEL;
            default: begin
              state_nx = IDLE;
`ifdef LT24_STREAM_EN
              stream_valid_nx = 1'b1;
`endif
            end
          endcase
        end
      end
    endcase

    // Bus pins are registered from the next-state view so they never glitch.
    {rs_nx, data_nx} = word_of(state_nx, idx_nx, x_nx, y_nx, pix_nx);
    wr_n_nx  = (state_nx == IDLE) | hi_nx;
    cs_n_nx  = (state_nx == IDLE);
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state   <= IDLE;
      idx     <= 2'd0;
      hi      <= 1'b0;
      cnt     <= '0;
      x_q     <= 8'h00;
      y_q     <= 9'h000;
      pix_q   <= 16'h0000;
      wr_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b1;
      data_q  <= 16'h0000;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      hi      <= hi_nx;
      cnt     <= cnt_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      pix_q   <= pix_nx;
      wr_n_q  <= wr_n_nx;
      cs_n_q  <= cs_n_nx;
      rs_q    <= rs_nx;
      data_q  <= data_nx;
      ready_q <= ready_nx;
    end
  end

`ifdef LT24_STREAM_EN
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      prev_x       <= 8'h00;
      prev_y       <= 9'h000;
      win_x0       <= 8'h00;
      stream_valid <= 1'b0;
    end else begin
      prev_x       <= prev_x_nx;
      prev_y       <= prev_y_nx;
      win_x0       <= win_x0_nx;
      stream_valid <= stream_valid_nx;
    end
  end
`endif

  assign bus.pixelReady = ready_q;
  assign bus.LT24Wr_n   = wr_n_q;
  assign bus.LT24Rd_n   = 1'b1;
  assign bus.LT24CS_n   = cs_n_q;
  assign bus.LT24RS     = rs_q;
  assign bus.LT24Data   = data_q;
endmodule
